// File: rtl/i2s_pkg.sv
`default_nettype none
// ============================================================================
// Module   : i2s_pkg
// Brief    : Shared channel encodings and defaults for the I2S link blocks.
// Revision : 1.0 - initial release
// ============================================================================
package i2s_pkg;

    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } channel_e;

    localparam int C_SAMPLE_WIDTH_DEFAULT = 16;

endpackage
`default_nettype wire

// File: rtl/i2s_sync.sv
`default_nettype none
// ============================================================================
// Module   : i2s_sync
// Brief    : N-stage input synchronizer with optional registered rising-edge pulse.
// Revision : 1.0 - initial release
// ============================================================================
module i2s_sync #(
    parameter int STAGES  = 2,
    parameter bit EDGE_EN = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q,
    output logic o_rise
);

    logic [STAGES-1:0] r_sync;
    logic              r_dly;

    // o_q is taken from the extra delay flop so the level output lines up
    // with the registered edge pulse on every instance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync <= '0;
            r_dly  <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
            r_dly  <= r_sync[STAGES-1];
        end
    end

    assign o_q = r_dly;

    generate
        if (EDGE_EN) begin : g_edge
            logic r_rise;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_rise <= 1'b0;
                end else begin
                    r_rise <= r_sync[STAGES-1] & ~r_dly;
                end
            end
            assign o_rise = r_rise;
        end else begin : g_no_edge
            assign o_rise = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/i2s_receiver.sv
`default_nettype none
// ============================================================================
// Module   : i2s_receiver
// Brief    : I2S capture deserializer; emits left/right pairs with a valid strobe.
// Revision : 1.0 - initial release
// ============================================================================
module i2s_receiver
    import i2s_pkg::*;
#(
    parameter int SAMPLE_WIDTH = C_SAMPLE_WIDTH_DEFAULT,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    bit_clk,
    input  logic                    frame_clk,
    input  logic                    sdata,
    output logic [SAMPLE_WIDTH-1:0] sample_left,
    output logic [SAMPLE_WIDTH-1:0] sample_right,
    output logic                    sample_valid,
    output logic                    short_slot,
    output logic                    locked
);

    localparam int               CNT_W  = $clog2(SAMPLE_WIDTH + 1);
    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(SAMPLE_WIDTH);

    logic w_bclk_rise, w_ws, w_sd;
    logic w_bclk_sync_unused, w_ws_rise_unused, w_sd_rise_unused;

    i2s_sync #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b1)) u_sync_bclk (
        .clk(clk), .reset(reset), .i_d(bit_clk), .o_q(w_bclk_sync_unused), .o_rise(w_bclk_rise)
    );
    i2s_sync #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b0)) u_sync_ws (
        .clk(clk), .reset(reset), .i_d(frame_clk), .o_q(w_ws), .o_rise(w_ws_rise_unused)
    );
    i2s_sync #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b0)) u_sync_sd (
        .clk(clk), .reset(reset), .i_d(sdata), .o_q(w_sd), .o_rise(w_sd_rise_unused)
    );

    logic [SAMPLE_WIDTH-1:0] r_shreg, r_left_hold, w_shreg_next, w_word;
    logic [SAMPLE_WIDTH:0]   w_shift_in;
    logic [CNT_W-1:0]        r_bit_cnt, w_cnt_next;
    channel_e                r_ws_prev;
    logic                    r_left_ok, w_has_room, w_slot_end;

    // Bits beyond SAMPLE_WIDTH are dropped so wide slots keep their MSBs.
    assign w_has_room   = (r_bit_cnt < C_FULL);
    assign w_shift_in   = {r_shreg, w_sd};
    assign w_shreg_next = w_has_room ? w_shift_in[SAMPLE_WIDTH-1:0] : r_shreg;
    assign w_cnt_next   = w_has_room ? (r_bit_cnt + CNT_W'(1)) : r_bit_cnt;
    assign w_word       = w_shreg_next << (C_FULL - w_cnt_next);
    assign w_slot_end   = (w_ws != r_ws_prev);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shreg      <= '0;
            r_bit_cnt    <= '0;
            r_left_hold  <= '0;
            r_left_ok    <= 1'b0;
            r_ws_prev    <= CH_LEFT;
            sample_left  <= '0;
            sample_right <= '0;
            sample_valid <= 1'b0;
            short_slot   <= 1'b0;
            locked       <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            short_slot   <= 1'b0;
            if (w_bclk_rise) begin
                r_ws_prev <= channel_e'(w_ws);
                if (w_slot_end) begin
                    r_shreg   <= '0;
                    r_bit_cnt <= '0;
                    // The first slot seen after reset is partial and only establishes alignment.
                    if (!locked) begin
                        locked <= 1'b1;
                    end else begin
                        short_slot <= (w_cnt_next < C_FULL);
                        if (r_ws_prev == CH_LEFT) begin
                            r_left_hold <= w_word;
                            r_left_ok   <= 1'b1;
                        end else if (r_left_ok) begin
                            sample_left  <= r_left_hold;
                            sample_right <= w_word;
                            sample_valid <= 1'b1;
                            r_left_ok    <= 1'b0;
                        end
                    end
                end else begin
                    r_shreg   <= w_shreg_next;
                    r_bit_cnt <= w_cnt_next;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2s_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2s_receiver
// Brief    : Self-checking bench for i2s_receiver with a slot-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2s_receiver;

    localparam int SW       = 16;
    localparam int CLK_HALF = 5;
    localparam int BIT_HALF = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          bit_clk = 1'b0;
    logic          frame_clk = 1'b0;
    logic          sdata = 1'b0;
    logic [SW-1:0] sample_left, sample_right;
    logic          sample_valid, short_slot, locked;

    i2s_receiver #(.SAMPLE_WIDTH(SW), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .bit_clk(bit_clk), .frame_clk(frame_clk), .sdata(sdata),
        .sample_left(sample_left), .sample_right(sample_right),
        .sample_valid(sample_valid), .short_slot(short_slot), .locked(locked)
    );

    always #CLK_HALF clk = ~clk;

    typedef struct { bit ws; bit sd; } bit_t;
    typedef struct {
        int            width;
        logic [31:0]   lval;
        logic [31:0]   rval;
        int            pre;
        int            frames;
        logic [SW-1:0] exp_l;
        logic [SW-1:0] exp_r;
    } vec_t;

    int               tests = 0;
    int               fails = 0;
    bit_t             stream[$];
    logic [2*SW-1:0]  dut_pairs[$];
    logic [2*SW-1:0]  mdl_pairs[$];
    int               dut_short = 0;
    int               mdl_short = 0;
    int               hold_bad = 0;
    int               lat_bad = 0;
    time              rise_time = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pulses must land 4 clk after the driver raises bit_clk, last one cycle,
    // and the sample outputs may only move together with sample_valid.
    initial begin
        logic [SW-1:0] pl, pr;
        logic          pv, ps;
        pl = '0; pr = '0; pv = 1'b0; ps = 1'b0;
        forever begin
            @(negedge clk);
            if (sample_valid) begin
                dut_pairs.push_back({sample_left, sample_right});
                if (($time - rise_time) != time'(4 * 2 * CLK_HALF)) lat_bad++;
            end
            if (short_slot) begin
                dut_short++;
                if (($time - rise_time) != time'(4 * 2 * CLK_HALF)) lat_bad++;
            end
            if (reset && !sample_valid && ({sample_left, sample_right} != {pl, pr})) hold_bad++;
            if ((sample_valid && pv) || (short_slot && ps)) hold_bad++;
            pl = sample_left; pr = sample_right; pv = sample_valid; ps = short_slot;
        end
    end

    initial begin
        #(3_000_000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_bit(input bit_t b);
        @(negedge clk);
        bit_clk = 1'b0; frame_clk = b.ws; sdata = b.sd;
        repeat (BIT_HALF) @(negedge clk);
        bit_clk = 1'b1; rise_time = $time;
        repeat (BIT_HALF - 1) @(negedge clk);
    endtask

    task automatic go_idle();
        @(negedge clk);
        bit_clk = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic clear_mon();
        dut_pairs.delete(); dut_short = 0; hold_bad = 0; lat_bad = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        bit_clk = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        clear_mon();
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // I2S framing: word select flips on the LSB of the slot it ends.
    function automatic void push_slot(input logic [31:0] val, input int width, input bit ch);
        for (int i = width - 1; i >= 0; i--) begin
            bit_t b;
            b.sd = val[i];
            b.ws = (i == 0) ? ~ch : ch;
            stream.push_back(b);
        end
    endfunction

    function automatic void build_stream(input vec_t v);
        int nf;
        stream.delete();
        for (int i = 0; i < v.pre; i++) begin
            bit_t b;
            b.ws = (i == v.pre - 1) ? 1'b0 : 1'b1;
            b.sd = 1'($urandom);
            stream.push_back(b);
        end
        nf = (v.pre > 0) ? v.frames : v.frames + 1;
        for (int f = 0; f < nf; f++) begin
            push_slot(v.lval, v.width, 1'b0);
            push_slot(v.rval, v.width, 1'b1);
        end
    endfunction

    function automatic logic [SW-1:0] scale(input logic [31:0] val, input int width);
        longint v;
        v = longint'(val) & ((64'd1 << width) - 64'd1);
        if (width >= SW) return SW'(v >> (width - SW));
        return SW'(v << (SW - width));
    endfunction

    // Slot-level reference: cut the stream into slots at word-select changes,
    // keep the first SW bits of each, then pair left with the following right.
    function automatic void run_model(input int start);
        bit            prev, lck, lok;
        logic [SW-1:0] hold;
        bit            slot[$];
        prev = 1'b0; lck = 1'b0; lok = 1'b0; hold = '0;
        mdl_pairs.delete(); mdl_short = 0;
        for (int k = start; k < stream.size(); k++) begin
            slot.push_back(stream[k].sd);
            if (stream[k].ws != prev) begin
                longint acc;
                acc = 0;
                for (int i = 0; i < SW; i++)
                    acc = acc * 2 + ((i < slot.size()) ? longint'(slot[i]) : 0);
                if (!lck) begin
                    lck = 1'b1;
                end else begin
                    if (slot.size() < SW) mdl_short++;
                    if (prev == 1'b0) begin
                        hold = SW'(acc); lok = 1'b1;
                    end else if (lok) begin
                        mdl_pairs.push_back({hold, SW'(acc)});
                        lok = 1'b0;
                    end
                end
                slot.delete();
            end
            prev = stream[k].ws;
        end
    endfunction

    task automatic compare_pairs(input string name);
        check({name, " valid count"}, dut_pairs.size(), mdl_pairs.size());
        for (int i = 0; i < dut_pairs.size() && i < mdl_pairs.size(); i++)
            check({name, " pair"}, dut_pairs[i], mdl_pairs[i]);
        check({name, " short count"}, dut_short, mdl_short);
        check({name, " hold/width"}, hold_bad, 0);
        check({name, " latency"}, lat_bad, 0);
    endtask

    task automatic run_vector(input vec_t v, input string name);
        logic [2*SW-1:0] last;
        build_stream(v);
        run_model(0);
        do_reset();
        foreach (stream[k]) send_bit(stream[k]);
        go_idle();
        compare_pairs(name);
        last = (dut_pairs.size() > 0) ? dut_pairs[$] : 'x;
        check({name, " last pair"}, last, {v.exp_l, v.exp_r});
        check({name, " locked"}, locked, 1'b1);
    endtask

    initial begin
        vec_t vecs[8];
        int   widths[4];
        int   cut;

        // Reset and idle behaviour
        repeat (3) @(negedge clk);
        check("reset sample_left", sample_left, 0);
        check("reset sample_right", sample_right, 0);
        check("reset sample_valid", sample_valid, 0);
        check("reset short_slot", short_slot, 0);
        check("reset locked", locked, 0);
        reset = 1'b1;
        repeat (30) @(negedge clk);
        check("idle valid count", dut_pairs.size(), 0);
        check("idle short count", dut_short, 0);
        check("idle locked", locked, 0);

        vecs[0] = '{16, 32'h0000_A5C3, 32'h0000_1234, 0, 3, 16'hA5C3, 16'h1234};
        vecs[1] = '{16, 32'h0000_A5C3, 32'h0000_1234, 6, 2, 16'hA5C3, 16'h1234};
        vecs[2] = '{32, 32'h8001_FFFF, 32'h7FFE_0000, 0, 2, 16'h8001, 16'h7FFE};
        vecs[3] = '{12, 32'h0000_0ABC, 32'h0000_0123, 0, 3, 16'hABC0, 16'h1230};
        widths = '{16, 24, 9, 2};
        for (int i = 4; i < 8; i++) begin
            vecs[i].width  = widths[i - 4];
            vecs[i].lval   = $urandom;
            vecs[i].rval   = $urandom;
            vecs[i].pre    = int'($urandom_range(0, 5));
            vecs[i].frames = 2;
            vecs[i].exp_l  = scale(vecs[i].lval, vecs[i].width);
            vecs[i].exp_r  = scale(vecs[i].rval, vecs[i].width);
        end
        for (int i = 0; i < 8; i++)
            run_vector(vecs[i], $sformatf("vec%0d w%0d", i, vecs[i].width));

        // Reset in the middle of a left slot, then the stream carries on
        do_reset();
        stream.delete();
        for (int f = 0; f < 5; f++) begin
            push_slot(32'($urandom_range(1, 16'hFFFF)), SW, 1'b0);
            push_slot(32'($urandom_range(1, 16'hFFFF)), SW, 1'b1);
        end
        run_model(0);
        cut = 4 * SW + 7;
        for (int k = 0; k < cut; k++) send_bit(stream[k]);
        check("pre-reset valid count", dut_pairs.size(), 1);
        if (dut_pairs.size() > 0) check("pre-reset pair", dut_pairs[0], mdl_pairs[0]);
        @(negedge clk);
        bit_clk = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("async reset sample_left", sample_left, 0);
        check("async reset sample_right", sample_right, 0);
        check("async reset locked", locked, 0);
        repeat (3) @(negedge clk);
        clear_mon();
        reset = 1'b1;
        run_model(cut);
        for (int k = cut; k < stream.size(); k++) send_bit(stream[k]);
        go_idle();
        compare_pairs("resume");
        check("resume valid count exact", dut_pairs.size(), 2);
        check("resume locked", locked, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/i2s_receiver.md
# i2s_receiver

Serial-audio input deserializer: the capture side of the I2S link driven by `i2s_controller`. It samples `bit_clk`, `frame_clk` and `sdata` from the codec ADC path, with clocks and data all treated as asynchronous to `clk`. It recovers left/right PCM words and presents each complete stereo pair to downstream logic with a one-cycle valid strobe. It sits on the `slow_clk` domain beside the transmitter in the APU.

## Interface

Parameters:
- `SAMPLE_WIDTH`, default 16: bits kept per channel, MSB-first.
- `SYNC_STAGES`, default 2: synchronizer flops on each serial input; minimum 2.

Ports:
- `clk` — input, 1 bit: system clock (`slow_clk` in the APU).
- `reset` — input, 1 bit: asynchronous, active-low reset.
- `bit_clk` — input, 1 bit: serial bit clock from the link.
- `frame_clk` — input, 1 bit: word select; 0 = left, 1 = right.
- `sdata` — input, 1 bit: serial data, MSB first.
- `sample_left` — output, `SAMPLE_WIDTH` bits: last complete left word.
- `sample_right` — output, `SAMPLE_WIDTH` bits: last complete right word.
- `sample_valid` — output, 1 bit: one-cycle pulse when both sample outputs update.
- `short_slot` — output, 1 bit: one-cycle pulse when a finished slot had fewer than `SAMPLE_WIDTH` bits.
- `locked` — output, 1 bit: high once a word-select edge has been seen since reset.

## Operation

- `bit_clk`, `frame_clk` and `sdata` each pass through `SYNC_STAGES` flops. `bclk_rise` is the synced `bit_clk` high while its one-cycle-delayed copy is low.
- All state changes happen only in cycles where `bclk_rise` = 1. Each such cycle:
  - The synced `sdata` bit belongs to the slot of `ws_prev`, the `frame_clk` value latched at the previous rise.
  - If `bit_cnt` < `SAMPLE_WIDTH`: shift the bit into `shreg` and increment `bit_cnt`. Otherwise discard the bit, so slots wider than `SAMPLE_WIDTH` keep only their MSBs, and `bit_cnt` saturates.
  - If synced `frame_clk` ≠ `ws_prev`, this bit was the LSB of the ending slot (I2S one-bit delay), so the slot is finalized.
- Finalizing a slot:
  - Word = `shreg` (including this bit), shifted left by `SAMPLE_WIDTH` − `bit_cnt` so short slots are zero-padded in the LSBs.
  - If `locked` = 0: discard the word (partial first slot), set `locked`, no `short_slot` pulse.
  - If `ws_prev` = 0 (left ended): hold the word in `left_hold` and set `left_ok`.
  - If `ws_prev` = 1 (right ended) and `left_ok` = 1: load `sample_left` ← `left_hold` and `sample_right` ← word together, pulse `sample_valid`, clear `left_ok`.
  - If `ws_prev` = 1 and `left_ok` = 0: discard the word, no valid pulse.
  - Pulse `short_slot` if the final `bit_cnt` < `SAMPLE_WIDTH` and `locked` was already 1.
  - Clear `shreg` and `bit_cnt`.
- Update `ws_prev` on every rise.
- `sample_left`/`sample_right` hold their values between pulses; they never change without `sample_valid`.

## Timing

- Reset values: all outputs, `shreg`, `bit_cnt`, `left_hold`, `left_ok`, `ws_prev` and the sync flops are 0. Reset takes effect immediately, including mid-slot, and the block re-locks from scratch.
- Latency, with `SYNC_STAGES` = 2: the clk edge that first registers `bit_clk` high is cycle 0.
  - `bclk_rise` is seen in cycle 2.
  - `sample_valid` and `short_slot` are high in cycle 3, for exactly one cycle.
  - Each additional sync stage adds 1 cycle.
- `sample_valid` and the new `sample_left`/`sample_right` values appear in the same cycle.
- Input constraint: `bit_clk` high and low phases each ≥ 2 `clk` periods. `frame_clk` and `sdata` change only near `bit_clk` falling edges. No behaviour is guaranteed outside this constraint.
- First `sample_valid` after reset: no earlier than the end of the first complete right slot that follows a complete left slot.

## Structure

- Shared package `i2s_pkg`:
  - channel encodings `CH_LEFT` = 0, `CH_RIGHT` = 1;
  - default `SAMPLE_WIDTH` = 16.
- `i2s_controller` uses the same package.
- Sub-module `i2s_sync`: an N-stage synchronizer with an optional rising-edge pulse output.
  - One instance on `bit_clk` with the edge output used.
  - One instance each on `frame_clk` and `sdata` with the edge output unused, so all three paths have equal delay.
- Bit counter width: `$clog2(SAMPLE_WIDTH+1)`.

## Test plan

- Reset: assert `reset` low for 3 cycles mid-stream → all outputs 0, `locked` = 0; release with idle inputs → no pulses.
- Nominal: `bit_clk` = `clk`/8, 16-bit slots, left 16'hA5C3, right 16'h1234, repeated 3 frames → after the first discarded partial slot, `sample_valid` pulses once per frame with left = A5C3, right = 1234, `short_slot` never high.
- Start mid-right-slot: no `sample_valid` until a full left slot followed by a full right slot; the first valid pair is correct.
- 32-bit slots: left 32'h8001_FFFF, right 32'h7FFE_0000 → left = 16'h8001, right = 16'h7FFE, no `short_slot`.
- 12-bit slots: left 12'hABC, right 12'h123 → left = 16'hABC0, right = 16'h1230, `short_slot` pulses twice per frame, `sample_valid` still pulses once.
- Reset asserted mid-left-slot, then the stream resumes → outputs 0 during reset; `locked` and valid pairs return exactly as in the mid-stream start case.
